// File: rtl/crc16_rx_check.sv
// crc16_rx_check: receive-side CRC-16/USB checker.
// Frames are N payload bytes followed by the CRC (low byte first). A 2-byte
// delay line holds back the trailing CRC bytes, so the payload is forwarded
// two bytes late with the CRC bytes stripped. End-of-frame status is registered
// and reported as a single done pulse. frame_len, calc_crc and rx_crc are
// held from one done pulse until the next.
module crc16_rx_check #(
  parameter int MAX_LEN = 1024,
  parameter int LEN_W   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_sop,
  input  logic             rx_eop,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             len_err,
  output logic [LEN_W-1:0] frame_len,
  output logic [15:0]      calc_crc,
  output logic [15:0]      rx_crc
);

  typedef enum logic [1:0] {IDLE, FILL0, FILL1, STREAM} state_e;

  state_e           state_q, state_d;
  logic [7:0]       d0_q, d0_d, d1_q, d1_d;
  logic [15:0]      crc_q, crc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [7:0]       out_data_q;
  logic             out_valid_q, out_sop_q, out_eop_q;
  logic             done_q, crc_ok_q, crc_err_q, len_err_q;
  logic [LEN_W-1:0] frame_len_q;
  logic [15:0]      calc_crc_q, rx_crc_q;

  logic             emit, emit_sop, emit_eop;
  logic             fin, fin_ok, fin_cerr, fin_lerr;
  logic [LEN_W-1:0] fin_len;
  logic [15:0]      fin_calc, fin_rx;

  // Reflected byte-wise CRC-16 update, polynomial 0xA001.
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  // Next-state: delay line shift, CRC/length accounting and end-of-frame status.
  always_comb begin
    state_d  = state_q;
    d0_d     = d0_q;
    d1_d     = d1_q;
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    emit     = 1'b0;
    emit_sop = 1'b0;
    emit_eop = 1'b0;
    fin      = 1'b0;
    fin_ok   = 1'b0;
    fin_cerr = 1'b0;
    fin_lerr = 1'b0;
    fin_len  = '0;
    fin_calc = '0;
    fin_rx   = '0;

    if (rx_valid) begin
      if (rx_sop) begin
        // A sop inside a frame aborts it; the sop byte always restarts.
        if (state_q != IDLE) begin
          fin      = 1'b1;
          fin_lerr = 1'b1;
          fin_len  = cnt_q;
          fin_calc = crc_q ^ 16'hFFFF;
        end
        if (rx_eop) begin
          // One-byte frame: cannot even hold a CRC.
          fin      = 1'b1;
          fin_lerr = 1'b1;
          fin_len  = '0;
          fin_calc = '0;
          state_d  = IDLE;
        end else begin
          state_d = FILL0;
          d0_d    = rx_data;
          crc_d   = 16'hFFFF;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end else begin
        case (state_q)
          IDLE: ;
          FILL0: begin
            if (rx_eop) begin
              // Two-byte frame: empty payload, CRC register untouched.
              fin      = 1'b1;
              fin_len  = cnt_q;
              fin_calc = crc_q ^ 16'hFFFF;
              fin_rx   = {rx_data, d0_q};
              fin_ok   = (fin_calc == fin_rx);
              fin_cerr = (fin_calc != fin_rx);
              state_d  = IDLE;
            end else begin
              d1_d    = d0_q;
              d0_d    = rx_data;
              state_d = FILL1;
            end
          end
          FILL1, STREAM: begin
            // d1 leaves the delay line as payload; CRC covers it even past MAX_LEN.
            crc_d = crc_upd(crc_q, d1_q);
            if (cnt_q < LEN_W'(MAX_LEN)) begin
              emit     = 1'b1;
              emit_sop = (state_q == FILL1);
              cnt_d    = cnt_q + LEN_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
            if (rx_eop) begin
              emit_eop = emit;
              fin      = 1'b1;
              fin_len  = cnt_d;
              fin_calc = crc_d ^ 16'hFFFF;
              fin_rx   = {rx_data, d0_q};
              fin_ok   = (fin_calc == fin_rx) && !ovf_d;
              fin_cerr = (fin_calc != fin_rx);
              fin_lerr = ovf_d;
              state_d  = IDLE;
            end else begin
              d1_d    = d0_q;
              d0_d    = rx_data;
              state_d = STREAM;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State, delay line and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      d0_q        <= '0;
      d1_q        <= '0;
      crc_q       <= 16'hFFFF;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      done_q      <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      frame_len_q <= '0;
      calc_crc_q  <= '0;
      rx_crc_q    <= '0;
    end else begin
      state_q     <= state_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= emit;
      out_sop_q   <= emit_sop;
      out_eop_q   <= emit_eop;
      if (emit) out_data_q <= d1_q;
      done_q      <= fin;
      crc_ok_q    <= fin_ok;
      crc_err_q   <= fin_cerr;
      len_err_q   <= fin_lerr;
      if (fin) begin
        frame_len_q <= fin_len;
        calc_crc_q  <= fin_calc;
        rx_crc_q    <= fin_rx;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign done      = done_q;
  assign crc_ok    = crc_ok_q;
  assign crc_err   = crc_err_q;
  assign len_err   = len_err_q;
  assign frame_len = frame_len_q;
  assign calc_crc  = calc_crc_q;
  assign rx_crc    = rx_crc_q;

endmodule

// File: tb/tb_crc16_rx_check.sv
// Bench for crc16_rx_check: stimulus pushes expected payload bytes and
// end-of-frame status into queues; a negedge monitor pops and compares.
module tb_crc16_rx_check;
  localparam int ML = 9;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid, rx_sop, rx_eop;
  logic [7:0]    out_data;
  logic          out_valid, out_sop, out_eop;
  logic          done, crc_ok, crc_err, len_err;
  logic [LW-1:0] frame_len;
  logic [15:0]   calc_crc, rx_crc;

  crc16_rx_check #(.MAX_LEN(ML), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .done(done), .crc_ok(crc_ok), .crc_err(crc_err), .len_err(len_err),
    .frame_len(frame_len), .calc_crc(calc_crc), .rx_crc(rx_crc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } pl_t;

  typedef struct packed {
    logic          ok;
    logic          cerr;
    logic          lerr;
    logic          chk_len;
    logic [LW-1:0] len;
    logic          chk_crc;
    logic [15:0]   calc;
    logic [15:0]   rx;
  } st_t;

  pl_t        exp_pl[$];
  st_t        exp_st[$];
  logic [7:0] fq[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, act, exp);
    end
  endtask

  // Bit-serial reference CRC-16/USB over the first n bytes of fq.
  function automatic logic [15:0] crc_ref(input int n);
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 16'hFFFF;
    for (int j = 0; j < n; j++) begin
      b = fq[j];
      for (int i = 0; i < 8; i++) begin
        fb = c[0] ^ b[i];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c ^ 16'hFFFF;
  endfunction

  task automatic drive(input logic [7:0] b, input logic sop, input logic eop);
    rx_valid = 1'b1; rx_data = b; rx_sop = sop; rx_eop = eop;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_frame(input bit gaps);
    int n;
    n = fq.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) idle(int'($urandom_range(0, 2)));
      drive(fq[i], i == 0, i == n - 1);
    end
  endtask

  // Expected forwarded bytes for np payload bytes at the head of fq.
  task automatic push_payload(input int np);
    pl_t p;
    for (int k = 0; k < np && k < ML; k++) begin
      p.d   = fq[k];
      p.sop = (k == 0);
      p.eop = (np <= ML) && (k == np - 1);
      exp_pl.push_back(p);
    end
  endtask

  task automatic push_st(input logic ok, input logic cerr, input logic lerr,
                         input logic chk_len, input logic [LW-1:0] len,
                         input logic chk_crc, input logic [15:0] calc, input logic [15:0] rx);
    st_t s;
    s.ok = ok; s.cerr = cerr; s.lerr = lerr; s.chk_len = chk_len; s.len = len;
    s.chk_crc = chk_crc; s.calc = calc; s.rx = rx;
    exp_st.push_back(s);
  endtask

  task automatic load_good();
    fq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
  endtask

  // Monitor: compare every DUT output event against the scoreboard.
  always @(negedge clk) begin
    pl_t p;
    st_t s;
    if (out_valid) begin
      if (exp_pl.size() == 0) begin
        checks++; errors++;
        $display("FAIL payload_unexpected got %0h exp none", out_data);
      end else begin
        p = exp_pl.pop_front();
        chk("payload", {out_data, out_sop, out_eop}, {p.d, p.sop, p.eop});
      end
    end
    if (done) begin
      if (exp_st.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected got %0b%0b%0b exp none", crc_ok, crc_err, len_err);
      end else begin
        s = exp_st.pop_front();
        chk("status_flags", {crc_ok, crc_err, len_err}, {s.ok, s.cerr, s.lerr});
        if (s.chk_len) chk("frame_len", frame_len, s.len);
        if (s.chk_crc) begin
          chk("calc_crc", calc_crc, s.calc);
          chk("rx_crc", rx_crc, s.rx);
        end
      end
    end else begin
      chk("flags_without_done", {crc_ok, crc_err, len_err}, 3'b000);
    end
  end

  initial begin
    logic [15:0] c;
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {out_valid, out_sop, out_eop, done, crc_ok, crc_err, len_err}, 7'b0);
    chk("reset_data", out_data, 8'h00);
    chk("reset_held", {frame_len, calc_crc, rx_crc}, '0);
    rst = 1'b0;
    idle(2);

    // Good frame "123456789" + B4C8.
    load_good();
    push_payload(9);
    push_st(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 1'b1, 16'hB4C8, 16'hB4C8);
    run_frame(1'b0);
    idle(3);

    // Corrupt payload byte: still forwarded, CRC mismatch.
    load_good();
    fq[4] = 8'h75;
    c = crc_ref(9);
    chk("corrupt_model_differs", {15'd0, c != 16'hB4C8}, 16'd1);
    push_payload(9);
    push_st(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b1, c, 16'hB4C8);
    run_frame(1'b0);
    idle(3);

    // Empty payload: 00 00.
    fq = '{8'h00, 8'h00};
    push_st(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 16'h0000, 16'h0000);
    run_frame(1'b0);
    idle(3);

    // Single byte with sop and eop.
    fq = '{8'h5A};
    push_st(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 16'h0, 16'h0);
    run_frame(1'b0);
    idle(3);

    // Gapped good frame, then a second one starting the cycle after eop.
    load_good();
    push_payload(9);
    push_st(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 1'b1, 16'hB4C8, 16'hB4C8);
    push_payload(9);
    push_st(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 1'b1, 16'hB4C8, 16'hB4C8);
    run_frame(1'b1);
    run_frame(1'b1);
    idle(3);

    // Abort: 5 bytes, then sop of a good frame. Only 31..33 had left the delay line.
    load_good();
    push_payload(3);
    exp_pl[$].eop = 1'b0;
    push_st(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++) drive(fq[i], i == 0, 1'b0);
    push_payload(9);
    push_st(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 1'b1, 16'hB4C8, 16'hB4C8);
    run_frame(1'b0);
    idle(3);

    // Overflow: ML+1 payload bytes with a correct CRC.
    fq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h30};
    c = crc_ref(10);
    fq.push_back(c[7:0]);
    fq.push_back(c[15:8]);
    push_payload(10);
    push_st(1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 1'b1, c, c);
    run_frame(1'b0);
    idle(3);

    // Reset after 5 bytes: no done, then a clean good frame.
    load_good();
    push_payload(3);
    exp_pl[$].eop = 1'b0;
    for (int i = 0; i < 5; i++) drive(fq[i], i == 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset_ctrl", {out_valid, out_sop, out_eop, done, crc_ok, crc_err, len_err}, 7'b0);
    chk("midreset_held", {frame_len, calc_crc, rx_crc}, '0);
    rst = 1'b0;
    idle(1);
    push_payload(9);
    push_st(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 1'b1, 16'hB4C8, 16'hB4C8);
    run_frame(1'b0);
    idle(5);

    chk("payload_queue_drained", exp_pl.size(), 0);
    chk("status_queue_drained", exp_st.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
